// File: rtl/dcsr_pkg.sv
// Shared definitions for the dCSR sequencing controller: state encoding and
// default geometry of the coefficient datapath.
package dcsr_pkg;

  localparam int DCSR_N   = 4;
  localparam int DCSR_W   = 4;
  localparam int DCSR_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/dcsr_ctrl.sv
// Sequencing controller for the dCSR serial datapath: accepts an operand set,
// loads it by pulsing dp_reset, gathers N serial coefficients, presents the result.
module dcsr_ctrl
  import dcsr_pkg::*;
#(
  parameter int N   = DCSR_N,
  parameter int W   = DCSR_W,
  parameter int LAT = DCSR_LAT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy,
  output logic           dp_reset,
  output logic [N*W-1:0] dp_ddata,
  input  logic [W-1:0]   dp_dcoef
);

  localparam int CW = $clog2(LAT + N);
  // Counter value at which the last coefficient arrives.
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT + N - 2);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N*W-1:0] hold;
  logic [N*W-1:0] result;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  // NOTE: hold and result are small flop registers with defined reset values,
  // so they are reset like the control state rather than left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hold   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          // Slot k is captured when cnt == k + LAT - 1.
          for (int i = 0; i < N; i++) begin
            if (cnt == CW'(LAT - 1 + i)) result[i*W +: W] <= dp_dcoef;
          end
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: outputs are decoded straight from state, so an asynchronous reset
  // forces dp_reset high immediately and holds the datapath without a clock.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dp_reset  = (state != RUN);
  assign dp_ddata  = hold;
  assign out_data  = result;

endmodule

// File: tb/tb_dcsr_ctrl.sv
// Self-checking bench for dcsr_ctrl: behavioural dCSR stubs with programmable
// coefficient sequences, a result scoreboard, and a LAT=1 and a LAT=3 instance.
module tb_dcsr_ctrl;
  import dcsr_pkg::*;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- LAT=1 instance ----------------
  logic           in_valid, in_ready, out_valid, out_ready, busy, dp_reset;
  logic [N*W-1:0] in_data, out_data, dp_ddata;
  logic [W-1:0]   dp_dcoef;
  logic [W-1:0]   seq [4];
  int             sc;
  logic [15:0]    exp_q [$];
  logic [15:0]    mon_exp;

  dcsr_ctrl #(.N(N), .W(W), .LAT(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dp_reset(dp_reset), .dp_ddata(dp_ddata), .dp_dcoef(dp_dcoef)
  );

  // Stub: coefficient k appears LAT edges after dp_reset falls, one per edge.
  always @(posedge clk) begin
    if (dp_reset) sc <= 0;
    else          sc <= sc + 1;
  end
  always_comb begin
    dp_dcoef = 4'hE;
    for (int k = 0; k < N; k++) if (sc == k) dp_dcoef = seq[k];
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %h, no result expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_fail++;
          $display("FAIL result_lat1: got %h, expected %h", out_data, mon_exp);
        end
      end
    end
  end

  // ---------------- LAT=3 instance ----------------
  logic           in_valid3, in_ready3, out_valid3, out_ready3, busy3, dp_reset3;
  logic [N*W-1:0] in_data3, out_data3, dp_ddata3;
  logic [W-1:0]   dp_dcoef3;
  logic [W-1:0]   seq3 [4];
  int             sc3;
  logic [15:0]    exp3_q [$];
  logic [15:0]    mon_exp3;

  dcsr_ctrl #(.N(N), .W(W), .LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .busy(busy3), .dp_reset(dp_reset3), .dp_ddata(dp_ddata3), .dp_dcoef(dp_dcoef3)
  );

  always @(posedge clk) begin
    if (dp_reset3) sc3 <= 0;
    else           sc3 <= sc3 + 1;
  end
  always_comb begin
    dp_dcoef3 = 4'hE;
    for (int k = 0; k < N; k++) if (sc3 == k + 2) dp_dcoef3 = seq3[k];
  end

  always @(negedge clk) begin
    if (reset && out_valid3 && out_ready3) begin
      n_checks++;
      if (exp3_q.size() == 0) begin
        n_fail++;
        $display("FAIL result3_unexpected: got %h, no result expected", out_data3);
      end else begin
        mon_exp3 = exp3_q.pop_front();
        if (out_data3 !== mon_exp3) begin
          n_fail++;
          $display("FAIL result_lat3: got %h, expected %h", out_data3, mon_exp3);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    seq  = '{4'h3, 4'h5, 4'h9, 4'hC};
    seq3 = '{4'h2, 4'hB, 4'h4, 4'h7};
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_data  = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, dp_reset, busy} !== 4'b1010) begin
        n_fail++;
        $display("FAIL reset_ctrl: ready/valid/dp_reset/busy=%b, expected 1010",
                 {in_ready, out_valid, dp_reset, busy});
      end
      n_checks++;
      if (out_data !== 16'h0 || dp_ddata !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_data: out_data=%h dp_ddata=%h, expected 0000 0000",
                 out_data, dp_ddata);
      end
    end
    n_checks++;
    if ({in_ready3, out_valid3, dp_reset3, busy3} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_lat3: ready/valid/dp_reset/busy=%b, expected 1010",
               {in_ready3, out_valid3, dp_reset3, busy3});
    end
    // reset stays asserted; test_single releases it together with in_valid
  endtask

  task automatic test_single();
    int edges, lo;
    bit got;
    @(posedge clk); #1;
    reset    = 1'b1;
    in_data  = 16'h016A;
    in_valid = 1'b1;
    exp_q.push_back(16'hC953);
    @(posedge clk); #1;               // E0: first edge after release accepts
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dp_reset, in_ready, busy} !== 3'b101 || dp_ddata !== 16'h016A) begin
      n_fail++;
      $display("FAIL load_phase: dp_reset/in_ready/busy=%b dp_ddata=%h, expected 101 016a",
               {dp_reset, in_ready, busy}, dp_ddata);
    end
    edges = 0; lo = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!dp_reset) lo++;
      if (out_valid) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL single_timeout: out_valid=0 after 20 edges, expected 1");
    end
    n_checks++;
    if (edges != 5) begin
      n_fail++;
      $display("FAIL single_latency: %0d edges, expected 5", edges);
    end
    n_checks++;
    if (lo != 4) begin
      n_fail++;
      $display("FAIL dp_reset_low: %0d cycles, expected 4", lo);
    end
    n_checks++;
    if (out_data !== 16'hC953) begin
      n_fail++;
      $display("FAIL single_data: got %h, expected c953", out_data);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_data !== 16'hC953 ||
          dp_ddata !== 16'h016A) begin
        n_fail++;
        $display("FAIL backpressure: valid/ready=%b out_data=%h dp_ddata=%h, expected 10 c953 016a",
                 {out_valid, in_ready}, out_data, dp_ddata);
      end
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL after_consume: ready/valid=%b, expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, t0, t1;
    bit switched, done;
    n_acc = 0; t0 = 0; t1 = 0; switched = 0; done = 0;
    @(posedge clk); #1;
    in_data  = 16'h016A;
    in_valid = 1'b1;
    exp_q.push_back(16'hC953);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid && !switched) begin
        seq = '{4'h1, 4'h2, 4'h7, 4'hE};
        switched = 1;
      end
      if (n_acc == 2 && exp_q.size() == 0) begin done = 1; break; end
      if (in_valid && in_ready) begin
        if (n_acc == 0) t0 = cyc + 1;
        else            t1 = cyc + 1;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc == 1) begin
          in_data = 16'hFFFF;
          exp_q.push_back(16'hE721);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL b2b_timeout: accepts=%0d pending=%0d, expected 2 and 0", n_acc, exp_q.size());
    end
    n_checks++;
    if (t1 - t0 != 7) begin
      n_fail++;
      $display("FAIL b2b_interval: %0d cycles, expected 7", t1 - t0);
    end
  endtask

  task automatic test_abort();
    bit got;
    seq = '{4'h8, 4'h6, 4'hA, 4'hF};
    @(posedge clk); #1;
    in_data  = 16'h5A5A;
    in_valid = 1'b1;
    @(posedge clk); #1;               // E0
    in_valid = 1'b0;
    repeat (3) @(posedge clk);        // E1..E3: now in the third RUN cycle
    #2;
    n_checks++;
    if (dp_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre: dp_reset=%b, expected 0", dp_reset);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({dp_reset, in_ready, out_valid, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL abort_async: dp_reset/ready/valid/busy=%b, expected 1100",
               {dp_reset, in_ready, out_valid, busy});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_partial: out_valid=%b, expected 0", out_valid);
      end
    end
    @(posedge clk); #1;
    in_data  = 16'h1234;
    in_valid = 1'b1;
    exp_q.push_back(16'hFA68);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dp_ddata !== 16'h1234) begin
      n_fail++;
      $display("FAIL abort_reload: dp_ddata=%h, expected 1234", dp_ddata);
    end
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!got || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_next: valid_seen=%0d pending=%0d, expected 1 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_param_sweep();
    int n_acc, t0, t1, first_valid, lo;
    bit done;
    n_acc = 0; t0 = 0; t1 = 0; first_valid = -1; lo = 0; done = 0;
    @(posedge clk); #1;
    out_ready3 = 1'b1;
    in_data3   = 16'h0F0F;
    in_valid3  = 1'b1;
    exp3_q.push_back(16'h74B2);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (n_acc >= 1 && first_valid < 0) begin
        if (!dp_reset3) lo++;
        if (out_valid3) first_valid = cyc;
      end
      if (n_acc == 2 && exp3_q.size() == 0) begin done = 1; break; end
      if (in_valid3 && in_ready3) begin
        if (n_acc == 0) t0 = cyc + 1;
        else            t1 = cyc + 1;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc == 1) begin
          in_data3 = 16'h1357;
          exp3_q.push_back(16'h74B2);
        end else begin
          in_valid3 = 1'b0;
        end
      end
    end
    in_valid3 = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL lat3_timeout: accepts=%0d pending=%0d, expected 2 and 0", n_acc, exp3_q.size());
    end
    n_checks++;
    if (first_valid - t0 != 7) begin
      n_fail++;
      $display("FAIL lat3_latency: %0d edges, expected 7", first_valid - t0);
    end
    n_checks++;
    if (lo != 6) begin
      n_fail++;
      $display("FAIL lat3_dp_reset_low: %0d cycles, expected 6", lo);
    end
    n_checks++;
    if (t1 - t0 != 9) begin
      n_fail++;
      $display("FAIL lat3_interval: %0d cycles, expected 9", t1 - t0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_param_sweep();
    n_checks++;
    if (exp_q.size() != 0 || exp3_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d/%0d, expected 0/0", exp_q.size(), exp3_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcsr_ctrl.md
# dcsr_ctrl

Sequencing controller for the `dCSR` serial polynomial-coefficient datapath. It accepts one packed operand set (N coefficients of W bits) over a valid/ready handshake, loads the operands into `dCSR` by pulsing the datapath reset, and collects the N output coefficients that `dCSR` emits one per cycle. It then presents the assembled result on a second valid/ready handshake. It sits between the operand source (host or preceding stage) and the `dCSR` instance, and owns that instance's `reset` and `ddata*` inputs.

## Interface
- `N`, default 4: number of coefficients per operand and per result.
- `W`, default 4: coefficient width in bits.
- `LAT`, default 1 (legal range ≥1): edges from the first edge with `dp_reset`=0 to the first edge at which `dp_dcoef` carries coefficient 0.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  operand set offered.
- `in_ready`  out  1  controller can accept an operand set.
- `in_data`  in  N*W  operands; coefficient i is at `[i*W +: W]`.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  N*W  result; coefficient k is at `[k*W +: W]`.
- `busy`  out  1  high in every state except IDLE.
- `dp_reset`  out  1  active-high load/reset to `dCSR.reset`.
- `dp_ddata`  out  N*W  to `dCSR.ddata0..ddata(N-1)`; slice i drives `ddata<i>`.
- `dp_dcoef`  in  W  from `dCSR.dcoef`.

## Operation
- **States**: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `in_ready`=1 and `dp_reset`=1.
  - When `in_valid` is high at an edge: `in_data` is latched into the hold register and the next state is LOAD.
- **LOAD**
  - Exactly one cycle with `dp_reset`=1.
  - `dp_ddata` equals the hold register, so `dCSR` captures the operands at the closing edge.
  - Next state is RUN, with `cnt` cleared to 0.
- **RUN**
  - `dp_reset`=0 and `cnt` increments every edge.
  - When `cnt` ≥ LAT-1, `dp_dcoef` is written to result slot k = `cnt`-(LAT-1).
  - After slot N-1 is written, the next state is DONE.
  - `cnt` width is `$clog2(LAT+N)`.
- **DONE**
  - `out_valid`=1 and `dp_reset`=1.
  - `out_data` is stable.
  - When `out_ready` is high at an edge, the next state is IDLE.
- `dp_ddata` is always driven from the hold register. The hold register changes only on an accepted input.
- `in_data` is ignored outside IDLE.
- The result register is written only in RUN and is never cleared by the handshake.
- No bypass: `in_ready` is 0 during the cycle in which the result is consumed.

## Timing
- **Reset values** (asserted asynchronously, while `reset`=0):
  - state = IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `dp_reset`=1
  - `out_data`=0
  - `dp_ddata`=0
  - `cnt`=0
- **Edge schedule**, with E0 the accepting edge:
  - LOAD lasts from E0 to E1.
  - Coefficient k is sampled at edge E(1+LAT+k).
  - `out_valid` rises after E(LAT+N).
  - Latency from accept to `out_valid` is LAT+N edges; this is 5 with the defaults.
- **Minimum issue interval**: LAT+N+2 cycles, i.e. 7 with the defaults, when `out_ready` is held at 1.
- **Handshake rules**:
  - `out_valid`, once high, stays high with `out_data` unchanged until `out_ready` is sampled high.
  - `out_ready` while `out_valid`=0 has no effect.
- **Reset mid-operation**: asserting `reset` in LOAD or RUN aborts the operation immediately.
  - `dp_reset` goes to 1 asynchronously, so `dCSR` is held.
  - No partial result is ever presented.
- **Release from reset** is synchronous to `clk`: the first transition out of IDLE can occur at the first edge after `reset` rises.

## Structure
- Shared package `dcsr_pkg`:
  - state encoding `typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE}`
  - default constants `DCSR_N`=4, `DCSR_W`=4, `DCSR_LAT`=1
- The controller is one module with no sub-modules.
- A wrapper, `dcsr_top`, instantiates `dcsr_ctrl` and `dCSR` and wires `dp_*` to the datapath ports.
- The bench drives `dcsr_ctrl` directly, with a behavioural datapath stub whose output sequence is programmable and appears LAT edges after `dp_reset` falls.

## Test plan
- **Reset defaults**: `reset`=0 for 3 cycles, with `in_valid` toggling → `in_ready`=1, `out_valid`=0, `dp_reset`=1, and no state change.
- **Single operation**:
  - Stimulus: `in_data`=16'h016A; stub emits 4'h3, 4'h5, 4'h9, 4'hC.
  - Required: `dp_ddata`=16'h016A during LOAD; `dp_reset` low for exactly 4 cycles; `out_valid` after 5 edges with `out_data`=16'hC953.
- **Backpressure**: hold `out_ready`=0 for 10 cycles → `out_valid` and `out_data`=16'hC953 stay stable; `in_ready`=0 throughout; a new `in_valid` is not accepted.
- **Back-to-back**:
  - Stimulus: two operands, 16'h016A and 16'hFFFF, with `out_ready`=1 and `in_valid` held high.
  - Required: second accept occurs 7 cycles after the first; results appear in order; the second result matches the stub sequence.
- **Abort**: drop `reset` at the third RUN cycle → `dp_reset`=1 in the same cycle; `out_valid` never rises; the next operation, 16'h1234, completes correctly.
- **Parameter sweep**: LAT=3, N=4 → coefficient 0 sampled at E4; `out_valid` after 7 edges; interval of 9 cycles.
